// File: rtl/imsic_msi_receiver.sv
// imsic_msi_receiver: AXI4 seteipnum_le responder decoding MSIs into a FWFT event FIFO; define MSI_RX_SLVERR_EN for SLVERR on bad decode
module imsic_msi_receiver #(
  parameter int NR_SRC = 32,
  parameter int NR_IMSICS = 4,
  parameter int NR_VS_FILES_PER_IMSIC = 1,
  parameter int NR_INTP_FILES = 2 + NR_VS_FILES_PER_IMSIC,
  parameter int AXI_ID_WIDTH = 4,
  parameter logic [31:0] BASE_ADDR = 32'h2400_0000,
  parameter int FIFO_DEPTH = 4,
  localparam int EIID_W = $clog2(NR_SRC),
  localparam int IMSIC_W = NR_IMSICS > 1 ? $clog2(NR_IMSICS) : 1,
  localparam int FILE_W = $clog2(NR_INTP_FILES)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [31:0]             i_awaddr,
  input  logic [AXI_ID_WIDTH-1:0] i_awid,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [31:0]             i_wdata,
  input  logic [3:0]              i_wstrb,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [AXI_ID_WIDTH-1:0] o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic [IMSIC_W-1:0]      o_evt_imsic,
  output logic [FILE_W-1:0]       o_evt_file,
  output logic [EIID_W-1:0]       o_evt_eiid
);
  localparam int FILES_P2 = 1 << FILE_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IMSIC_W + FILE_W + EIID_W;
  typedef enum logic [1:0] {IDLE, PUSH, RESP} state_t;
  state_t state, state_n;
  logic aw_held, w_held, aw_hs, w_hs, dec_ok, full, push, pop;
  logic [31:0] awaddr_q, wdata_q, off, page, imsic_idx, file_idx;
  logic [3:0] wstrb_q;
  logic [AXI_ID_WIDTH-1:0] awid_q;
  logic [1:0] bresp_q;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  assign o_awready = ~i_rst & (state == IDLE) & ~aw_held;
  assign o_wready = ~i_rst & (state == IDLE) & ~w_held;
  assign aw_hs = i_awvalid & o_awready;
  assign w_hs = i_wvalid & o_wready;
  assign off = awaddr_q - BASE_ADDR;
  assign page = {12'd0, off[31:12]};
  assign imsic_idx = page >> FILE_W;
  assign file_idx = page & 32'(FILES_P2 - 1);
  assign dec_ok = awaddr_q >= BASE_ADDR && off[11:0] == 12'd0 && imsic_idx < 32'(NR_IMSICS) &&
                  file_idx < 32'(NR_INTP_FILES) && wstrb_q == 4'hF && wdata_q < 32'(NR_SRC) && wdata_q != 32'd0;
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign push = (state == PUSH) & dec_ok & ~full;
  assign o_evt_valid = count != '0;
  assign pop = o_evt_valid & i_evt_ready;
  assign {o_evt_imsic, o_evt_file, o_evt_eiid} = o_evt_valid ? mem[rptr] : '0;
  assign o_bvalid = state == RESP;
  assign o_bid = awid_q;
  assign o_bresp = bresp_q;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (((aw_held | aw_hs) & (w_held | w_hs)) ? PUSH : IDLE) :
              state == PUSH ? ((dec_ok & full) ? PUSH : RESP) :
              (i_bready ? IDLE : RESP);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      awaddr_q <= '0;
      awid_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
    end else begin
      state <= state_n;
      if (aw_hs) begin
        aw_held <= 1'b1;
        awaddr_q <= i_awaddr;
        awid_q <= i_awid;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        wdata_q <= i_wdata;
        wstrb_q <= i_wstrb;
      end
      if (state == RESP && i_bready) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
      end
      if (state == PUSH && state_n == RESP)
`ifdef MSI_RX_SLVERR_EN
        bresp_q <= dec_ok ? 2'b00 : 2'b10;
`else
        bresp_q <= 2'b00;
`endif
    end
  end
  // Pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge i_clk)
    if (push) mem[wptr] <= {imsic_idx[IMSIC_W-1:0], file_idx[FILE_W-1:0], wdata_q[EIID_W-1:0]};
endmodule

// File: tb/tb_imsic_msi_receiver.sv
// tb_imsic_msi_receiver: directed bench with a queue-based decode model checked every cycle
module tb_imsic_msi_receiver;
  localparam logic [31:0] BASE = 32'h2400_0000;
  logic i_clk = 0, i_rst = 1;
  logic i_awvalid = 0, i_wvalid = 0, i_bready = 1, i_evt_ready = 0;
  logic [31:0] i_awaddr = 0, i_wdata = 0;
  logic [3:0] i_awid = 0, i_wstrb = 0;
  logic o_awready, o_wready, o_bvalid, o_evt_valid;
  logic [3:0] o_bid;
  logic [1:0] o_bresp, o_evt_imsic, o_evt_file;
  logic [4:0] o_evt_eiid;
  int checks = 0, errors = 0;
  typedef struct {int im; int f; int e;} evt_t;
  evt_t exp_evt[$];
  int exp_bid[$];
  int exp_resp[$];
  always #5 i_clk = ~i_clk;
  imsic_msi_receiver dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awid(i_awid),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
    .o_evt_imsic(o_evt_imsic), .o_evt_file(o_evt_file), .o_evt_eiid(o_evt_eiid)
  );
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // Address map: each 4 KiB page is one file; four file slots per IMSIC
  function automatic bit model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output evt_t ev);
    longint off, pg;
    ev = '{0, 0, 0};
    if (a < BASE) return 0;
    off = longint'(a - BASE);
    pg = off / 4096;
    ev.im = int'(pg / 4);
    ev.f = int'(pg % 4);
    ev.e = int'(d[4:0]);
    return off % 4096 == 0 && ev.im < 4 && ev.f < 3 && s == 4'hF && d < 32 && d != 0;
  endfunction
  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [3:0] id);
    evt_t ev;
    bit v;
    v = model(a, d, s, ev);
    if (v) exp_evt.push_back(ev);
    exp_bid.push_back(int'(id));
`ifdef MSI_RX_SLVERR_EN
    exp_resp.push_back(v ? 0 : 2);
`else
    exp_resp.push_back(0);
`endif
  endtask
  always @(negedge i_clk) if (!i_rst) begin
    if (exp_bid.size() == 0) chk("b_spurious", o_bvalid, 0);
    else if (o_bvalid && i_bready) begin
      chk("bid", o_bid, exp_bid.pop_front());
      chk("bresp", o_bresp, exp_resp.pop_front());
    end
    if (exp_evt.size() == 0) chk("evt_spurious", o_evt_valid, 0);
    else if (o_evt_valid) begin
      chk("evt_imsic", o_evt_imsic, exp_evt[0].im);
      chk("evt_file", o_evt_file, exp_evt[0].f);
      chk("evt_eiid", o_evt_eiid, exp_evt[0].e);
      if (i_evt_ready) void'(exp_evt.pop_front());
    end
  end
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [3:0] id, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, awh, wh;
    int t = 0;
    expect_write(a, d, s, id);
    i_awaddr = a; i_awid = id; i_wdata = d; i_wstrb = s;
    while (!(aw_done && w_done) && t < 200) begin
      i_awvalid = !aw_done && t >= aw_dly;
      i_wvalid = !w_done && t >= w_dly;
      @(negedge i_clk);
      awh = i_awvalid && o_awready;
      wh = i_wvalid && o_wready;
      @(posedge i_clk); #1;
      if (awh) aw_done = 1;
      if (wh) w_done = 1;
      t++;
    end
    i_awvalid = 0; i_wvalid = 0;
    chk("write_accept", aw_done && w_done, 1);
  endtask
  task automatic drain(input bit evts);
    int t = 0;
    while ((exp_bid.size() != 0 || (evts && exp_evt.size() != 0)) && t < 100) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk("drain_done", t < 100, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] bad_a [7];
    logic [31:0] bad_d [7];
    logic [3:0] bad_s [7];
    int pg [5];
    int dd [5];
    evt_t ev;
    bad_a = '{BASE + 32'h1000, BASE + 32'h1000, BASE + 32'h3000, BASE + 32'h1004, BASE + 32'h1000, BASE - 32'h1000, BASE + 32'h10000};
    bad_d = '{0, 32, 5, 5, 5, 5, 5};
    bad_s = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF};
    pg = '{0, 1, 2, 4, 9};
    dd = '{1, 2, 3, 4, 30};
    chk("model_pin_valid", model(BASE + 32'h9000, 30, 4'hF, ev), 1);
    chk("model_pin_imsic", ev.im, 2);
    chk("model_pin_file", ev.f, 1);
    chk("model_pin_bad_file", model(BASE + 32'h7000, 3, 4'hF, ev), 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_awready", o_awready, 0);
    chk("rst_wready", o_wready, 0);
    chk("rst_bvalid", o_bvalid, 0);
    chk("rst_evt_valid", o_evt_valid, 0);
    chk("rst_bid", o_bid, 0);
    chk("rst_bresp", o_bresp, 0);
    i_rst = 0;
    #1;
    chk("idle_awready", o_awready, 1);
    chk("idle_wready", o_wready, 1);
    axi_write(BASE + 32'h1000, 5, 4'hF, 3, 0, 0);
    chk("t1_bvalid_early", o_bvalid, 0);
    @(posedge i_clk); #1;
    chk("t1_bvalid", o_bvalid, 1);
    chk("t1_bid", o_bid, 3);
    chk("t1_bresp", o_bresp, 0);
    chk("t1_evt_valid", o_evt_valid, 1);
    chk("t1_imsic", o_evt_imsic, 0);
    chk("t1_file", o_evt_file, 1);
    chk("t1_eiid", o_evt_eiid, 5);
    i_evt_ready = 1;
    drain(1);
    i_evt_ready = 0;
    axi_write(BASE + 32'h6000, 31, 4'hF, 7, 3, 0);
    @(posedge i_clk); #1;
    chk("t2_imsic", o_evt_imsic, 1);
    chk("t2_file", o_evt_file, 2);
    chk("t2_eiid", o_evt_eiid, 31);
    i_evt_ready = 1;
    drain(1);
    i_evt_ready = 0;
    for (int i = 0; i < 7; i++) axi_write(bad_a[i], bad_d[i], bad_s[i], 4'(i), 0, 0);
    drain(0);
    chk("t3_no_evt", o_evt_valid, 0);
    for (int i = 0; i < 5; i++) axi_write(BASE + 32'(pg[i]) * 32'h1000, 32'(dd[i]), 4'hF, 4'(i + 8), 0, 0);
    repeat (4) begin
      @(posedge i_clk); #1;
      chk("t4_stall_bvalid", o_bvalid, 0);
      chk("t4_stall_awready", o_awready, 0);
    end
    chk("t4_head_eiid", o_evt_eiid, 1);
    i_evt_ready = 1;
    @(posedge i_clk); #1;
    i_evt_ready = 0;
    chk("t4_bvalid_after_pop", o_bvalid, 0);
    @(posedge i_clk); #1;
    chk("t4_bvalid", o_bvalid, 1);
    chk("t4_bid", o_bid, 12);
    i_evt_ready = 1;
    drain(1);
    i_bready = 0;
    axi_write(BASE + 32'h2000, 9, 4'hF, 2, 0, 0);
    i_awaddr = BASE + 32'h4000; i_wdata = 11; i_awid = 6;
    i_awvalid = 1; i_wvalid = 1;
    repeat (10) begin
      @(negedge i_clk);
      chk("t5_awready", o_awready, 0);
      chk("t5_wready", o_wready, 0);
    end
    chk("t5_bvalid_held", o_bvalid, 1);
    chk("t5_bid_held", o_bid, 2);
    @(posedge i_clk); #1;
    i_awvalid = 0; i_wvalid = 0;
    i_bready = 1;
    axi_write(BASE + 32'h4000, 11, 4'hF, 6, 0, 0);
    drain(1);
    i_evt_ready = 0;
    axi_write(BASE + 32'h1000, 7, 4'hF, 1, 0, 0);
    axi_write(BASE + 32'h8000, 8, 4'hF, 4, 0, 0);
    drain(0);
    i_bready = 0;
    axi_write(BASE + 32'h1000, 0, 4'hF, 5, 0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("t6_bvalid_pre", o_bvalid, 1);
    chk("t6_evt_valid_pre", o_evt_valid, 1);
    i_rst = 1;
    exp_evt.delete();
    exp_bid.delete();
    exp_resp.delete();
    #1;
    chk("t6_bvalid_rst", o_bvalid, 0);
    chk("t6_evt_valid_rst", o_evt_valid, 0);
    chk("t6_awready_rst", o_awready, 0);
    @(posedge i_clk); #1;
    i_rst = 0; i_bready = 1; i_evt_ready = 1;
    axi_write(BASE + 32'h5000, 17, 4'hF, 9, 1, 0);
    drain(1);
    chk("queues_empty", exp_evt.size() + exp_bid.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
